// File: rtl/trunc_sub_pkg.sv
// ============================================================================
// Module  : trunc_sub_pkg
// Brief   : Shared types and helpers for the trunc_sub_serial block.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package trunc_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FILL_ZEROS = 0;
    localparam int FILL_ONES  = 1;

    function automatic int ndig(input int width, input int k, input int digit);
        return (width - k + digit - 1) / digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trunc_sub_serial_if.sv
// ============================================================================
// Module  : trunc_sub_serial_if
// Brief   : Operand/result handshake bundle; err_out exists only when
//           TRUNC_SUB_ERR_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface trunc_sub_serial_if #(
    parameter int BIT_WIDTH = 8,
    parameter int K         = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH:0]   out_data;
`ifdef TRUNC_SUB_ERR_EN
    logic signed [K+1:0]  err_out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_data, err_out
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_data, err_out
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

`default_nettype wire

// File: rtl/trunc_sub_serial_digit.sv
// ============================================================================
// Module  : sub_digit
// Brief   : Combinational DIGIT-bit subtractor with borrow-in / borrow-out.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sub_digit #(
    parameter int DIGIT = 2
) (
    input  wire logic [DIGIT-1:0] a,
    input  wire logic [DIGIT-1:0] b,
    input  wire logic             bin,
    output logic      [DIGIT-1:0] diff,
    output logic                  bout
);

    logic [DIGIT:0] w_full;

    always_comb begin
        w_full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    end

    assign diff = w_full[DIGIT-1:0];
    assign bout = w_full[DIGIT];

endmodule

`default_nettype wire

// File: rtl/trunc_sub_serial.sv
// ============================================================================
// Module  : trunc_sub_serial
// Brief   : Digit-serial truncated approximate subtractor (A-B on bits
//           [BIT_WIDTH-1:K], low K bits filled). Optional macro
//           TRUNC_SUB_ERR_EN adds the signed truncation-error output err_out.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module trunc_sub_serial
    import trunc_sub_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int K         = 3,
    parameter int DIGIT     = 2,
    parameter int FILL      = FILL_ZEROS
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    trunc_sub_serial_if.slave bus
);

    localparam int UW   = BIT_WIDTH - K;
    localparam int NDIG = ndig(BIT_WIDTH, K, DIGIT);
    localparam int PW   = NDIG * DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic       FILL_BIT = (FILL == FILL_ONES);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_CALC   = CALC;
    localparam logic [1:0] S_DONE   = DONE;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_borrow;
    logic [PW-1:0]      r_a_sh;
    logic [PW-1:0]      r_b_sh;
    logic [PW-1:0]      r_res;
    logic [BIT_WIDTH:0] r_out;

    logic [PW-1:0]      w_a_up;
    logic [PW-1:0]      w_b_up;
    logic [DIGIT-1:0]   w_diff;
    logic               w_bout;
    logic [PW-1:0]      w_res_next;
    logic [BIT_WIDTH:0] w_out_next;
    logic               w_last;
    logic               w_accept;
    logic               w_finish;

    // Zero-padding the upper field to a whole number of digits keeps the
    // borrow of a short final digit equal to the borrow out of the true MSB.
    always_comb begin
        w_a_up         = '0;
        w_b_up         = '0;
        w_a_up[UW-1:0] = bus.a[BIT_WIDTH-1:K];
        w_b_up[UW-1:0] = bus.b[BIT_WIDTH-1:K];
    end

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .a    (r_a_sh[DIGIT-1:0]),
        .b    (r_b_sh[DIGIT-1:0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    // New digits enter at the top and migrate down; after NDIG steps digit 0
    // sits at bit 0 of the result register.
    assign w_res_next = (r_res >> DIGIT) | (PW'(w_diff) << (PW - DIGIT));

    always_comb begin
        w_out_next                  = '0;
        w_out_next[BIT_WIDTH]       = w_bout;
        w_out_next[BIT_WIDTH-1:K]   = w_res_next[UW-1:0];
        for (int i = 0; i < K; i++) begin
            w_out_next[i] = FILL_BIT;
        end
    end

    assign w_last   = (r_cnt == CW'(NDIG - 1));
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_finish = (r_state == S_CALC) && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_out    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh   <= w_a_up;
                        r_b_sh   <= w_b_up;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_res    <= '0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a_sh   <= r_a_sh >> DIGIT;
                    r_b_sh   <= r_b_sh >> DIGIT;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out   <= w_out_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = r_out;

`ifdef TRUNC_SUB_ERR_EN
    if (K > 0) begin : g_err
        localparam int               FILL_ERR_INT = (FILL == FILL_ONES) ? ((1 << K) - 1) : 0;
        localparam logic signed [K+1:0] FILL_ERR  = FILL_ERR_INT[K+1:0];

        logic [K-1:0]        r_a_lo;
        logic [K-1:0]        r_b_lo;
        logic signed [K+1:0] r_err;
        logic signed [K+1:0] w_err;

        assign w_err = $signed({2'b00, r_a_lo}) - $signed({2'b00, r_b_lo}) - FILL_ERR;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_lo <= '0;
                r_b_lo <= '0;
                r_err  <= '0;
            end else begin
                if (w_accept) begin
                    r_a_lo <= bus.a[K-1:0];
                    r_b_lo <= bus.b[K-1:0];
                end
                if (w_finish) begin
                    r_err <= w_err;
                end
            end
        end

        assign bus.err_out = r_err;
    end else begin : g_err_k0
        assign bus.err_out = '0;
    end
`else
    if (K > 0) begin : g_lo_sink
        logic w_unused_lo;
        assign w_unused_lo = ^{bus.a[K-1:0], bus.b[K-1:0], w_accept};
    end else begin : g_acc_sink
        logic w_unused_acc;
        assign w_unused_acc = w_accept;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_trunc_sub_serial.sv
// ============================================================================
// Module  : tb_trunc_sub_serial
// Brief   : Self-checking bench driving three configurations in lockstep.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trunc_sub_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a_s = '0;
    logic [7:0] b_s = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trunc_sub_serial_if #(.BIT_WIDTH(8), .K(3)) i0 ();
    trunc_sub_serial_if #(.BIT_WIDTH(8), .K(3)) i1 ();
    trunc_sub_serial_if #(.BIT_WIDTH(8), .K(0)) i2 ();

    assign i0.in_valid = in_valid;  assign i0.out_ready = out_ready;
    assign i0.a = a_s;              assign i0.b = b_s;
    assign i1.in_valid = in_valid;  assign i1.out_ready = out_ready;
    assign i1.a = a_s;              assign i1.b = b_s;
    assign i2.in_valid = in_valid;  assign i2.out_ready = out_ready;
    assign i2.a = a_s;              assign i2.b = b_s;

    trunc_sub_serial #(.BIT_WIDTH(8), .K(3), .DIGIT(2), .FILL(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    trunc_sub_serial #(.BIT_WIDTH(8), .K(3), .DIGIT(2), .FILL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    trunc_sub_serial #(.BIT_WIDTH(8), .K(0), .DIGIT(8), .FILL(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] e0;
        logic [8:0] e1;
        logic [8:0] e2;
        int         r0;
        int         r1;
        int         r2;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: upper-field difference as a (9-K)-bit two's-complement value.
    function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv, input int k, input int fill);
        int d;
        int res;
        d   = int'(av >> k) - int'(bv >> k);
        res = (d & ((1 << (9 - k)) - 1)) << k;
        if (fill == 1) res = res | ((1 << k) - 1);
        return res[8:0];
    endfunction

    function automatic int err_model(input logic [7:0] av, input logic [7:0] bv, input int k, input int fill);
        int m;
        if (k == 0) return 0;
        m = (1 << k) - 1;
        return int'(av & m) - int'(bv & m) - ((fill == 1) ? m : 0);
    endfunction

    task automatic run_txn(input logic [7:0] av, input logic [7:0] bv,
                           input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                           input int r0, input int r1, input int r2,
                           input int hold, input string tag);
        int l0, l1, l2;
        @(negedge clk);
        a_s = av; b_s = bv; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "_in_ready_idle"}, {i0.in_ready, i1.in_ready, i2.in_ready}, 3'b111);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, {i0.in_ready, i1.in_ready, i2.in_ready}, 3'b000);
        chk({tag, "_valid_early"}, {i0.out_valid, i1.out_valid, i2.out_valid}, 3'b000);
        l0 = -1; l1 = -1; l2 = -1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (i0.out_valid && l0 < 0) l0 = c;
            if (i1.out_valid && l1 < 0) l1 = c;
            if (i2.out_valid && l2 < 0) l2 = c;
            if (l0 >= 0 && l1 >= 0 && l2 >= 0) break;
        end
        chk({tag, "_lat0"}, l0, (8 - 3 + 2 - 1) / 2);
        chk({tag, "_lat1"}, l1, (8 - 3 + 2 - 1) / 2);
        chk({tag, "_lat2"}, l2, (8 - 0 + 8 - 1) / 8);
        chk({tag, "_data0"}, i0.out_data, e0);
        chk({tag, "_data1"}, i1.out_data, e1);
        chk({tag, "_data2"}, i2.out_data, e2);
`ifdef TRUNC_SUB_ERR_EN
        chk({tag, "_err0"}, int'(i0.err_out), r0);
        chk({tag, "_err1"}, int'(i1.err_out), r1);
        chk({tag, "_err2"}, int'(i2.err_out), r2);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; a_s = ~av; b_s = ~bv;
            @(posedge clk); #1;
            chk({tag, "_bp_data0"}, i0.out_data, e0);
            chk({tag, "_bp_data2"}, i2.out_data, e2);
            chk({tag, "_bp_valid"}, {i0.out_valid, i1.out_valid, i2.out_valid}, 3'b111);
            chk({tag, "_bp_in_ready"}, {i0.in_ready, i1.in_ready, i2.in_ready}, 3'b000);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_back"}, {i0.in_ready, i1.in_ready, i2.in_ready}, 3'b111);
        chk({tag, "_valid_drop"}, {i0.out_valid, i1.out_valid, i2.out_valid}, 3'b000);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, {i0.in_ready, i1.in_ready, i2.in_ready}, 3'b111);
        chk({tag, "_out_valid"}, {i0.out_valid, i1.out_valid, i2.out_valid}, 3'b000);
        chk({tag, "_data0"}, i0.out_data, 0);
        chk({tag, "_data1"}, i1.out_data, 0);
        chk({tag, "_data2"}, i2.out_data, 0);
`ifdef TRUNC_SUB_ERR_EN
        chk({tag, "_err0"}, int'(i0.err_out), 0);
        chk({tag, "_err1"}, int'(i1.err_out), 0);
`endif
    endtask

    initial begin
        logic [7:0] ra, rb;

        vt[0] = '{8'hB5, 8'h4C, 9'h068, 9'h06F, 9'h069,  1,  -6, 0};
        vt[1] = '{8'h10, 8'h20, 9'h1F0, 9'h1F7, 9'h1F0,  0,  -7, 0};
        vt[2] = '{8'h00, 8'h01, 9'h000, 9'h007, 9'h1FF, -1,  -8, 0};
        vt[3] = '{8'hFF, 8'h00, 9'h0F8, 9'h0FF, 9'h0FF,  7,   0, 0};
        vt[4] = '{8'h00, 8'hFF, 9'h108, 9'h10F, 9'h101, -7, -14, 0};

        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_txn(vt[i].a, vt[i].b, vt[i].e0, vt[i].e1, vt[i].e2,
                    vt[i].r0, vt[i].r1, vt[i].r2, 0, $sformatf("vec%0d", i));
        end

        run_txn(vt[1].a, vt[1].b, vt[1].e0, vt[1].e1, vt[1].e2,
                vt[1].r0, vt[1].r1, vt[1].r2, 5, "backpressure");
        run_txn(vt[3].a, vt[3].b, vt[3].e0, vt[3].e1, vt[3].e2,
                vt[3].r0, vt[3].r1, vt[3].r2, 0, "after_bp");

        // Abort a borrow-heavy transaction during its second CALC cycle.
        @(negedge clk);
        a_s = 8'h00; b_s = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vt[0].a, vt[0].b, vt[0].e0, vt[0].e1, vt[0].e2,
                vt[0].r0, vt[0].r1, vt[0].r2, 0, "post_reset");

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_txn(ra, rb, model(ra, rb, 3, 0), model(ra, rb, 3, 1), model(ra, rb, 0, 0),
                    err_model(ra, rb, 3, 0), err_model(ra, rb, 3, 1), err_model(ra, rb, 0, 0),
                    0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
